// File: rtl/jk_count_driver.sv
// Excitation driver for an external bank of JK flip-flops counting modulo MODULUS, with load and mismatch detection.
// Build option JK_TOGGLE_EN: drive changing bits with toggle (11) instead of set/clear (10/01).
module jk_count_driver #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic [WIDTH-1:0]     q_fb,
    output logic [2*WIDTH-1:0]   jk,
    output logic [WIDTH-1:0]     q_model,
    output logic                 tc,
    output logic                 fault,
    output logic                 load_err
);

    // state | meaning
    // CLEAR | drive clear on every bit; flip-flops have no reset of their own
    // RUN   | count/load, compare q_fb against the shadow model each edge
    // FAULT | q_fb diverged from the model; hold all bits until rst
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TOP_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_V = (WIDTH + 1)'(MODULUS);

    state_t             state_q;
    logic [WIDTH-1:0]   q_model_q;
    logic [WIDTH-1:0]   nxt_d;
    logic               fault_q;
    logic               load_err_q;
    logic               load_bad;

    // Compare one bit wider so MODULUS == 2**WIDTH is representable.
    assign load_bad = load && ({1'b0, load_val} >= MOD_V);

    always_comb begin
        nxt_d = q_fb;
        if (load) begin
            if (!load_bad) begin
                nxt_d = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                nxt_d = (q_fb == TOP_V) ? '0 : q_fb + 1'b1;
            end else begin
                nxt_d = (q_fb == '0) ? TOP_V : q_fb - 1'b1;
            end
        end
    end

    always_comb begin
        jk = '0;
        case (state_q)
            CLEAR: begin
                for (int i = 0; i < WIDTH; i++) begin
                    jk[2*i +: 2] = 2'b01;
                end
            end
            RUN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (q_fb[i] != nxt_d[i]) begin
`ifdef JK_TOGGLE_EN
                        jk[2*i +: 2] = 2'b11;
`else
                        jk[2*i +: 2] = {nxt_d[i], q_fb[i]};
`endif
                    end
                end
            end
            default: jk = '0;
        endcase
    end

    assign tc = (state_q == RUN) && en && !load &&
                (up_dn ? (q_fb == TOP_V) : (q_fb == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            q_model_q  <= '0;
            fault_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    state_q   <= RUN;
                    q_model_q <= '0;
                end
                RUN: begin
                    if (q_fb != q_model_q) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        q_model_q  <= nxt_d;
                        load_err_q <= load_bad;
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign q_model  = q_model_q;
    assign fault    = fault_q;
    assign load_err = load_err_q;

endmodule

// File: doc/jk_count_driver.md
Name: jk_count_driver

Overview:
- Excitation/sequencing stage that sits directly upstream of a bank of WIDTH JK flip-flops. It drives each flip-flop's {J,K} pair so the bank counts modulo MODULUS, up or down, with a parallel load.
- The flip-flop outputs return on q_fb. The block keeps a shadow model of the expected state and flags any divergence between that model and q_fb.
- The flip-flops have no reset of their own, so this block clears them through excitation codes after reset.

Parameters:
- WIDTH, 4, number of JK flip-flops driven.
- MODULUS, 10, count modulus. Legal range is 2..2^WIDTH.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  parallel-load request; takes priority over en.
- load_val  input  WIDTH  value to load.
- q_fb  input  WIDTH  Q outputs of the downstream flip-flops.
- jk  output  2*WIDTH  excitation; bit i uses jk[2i+1:2i] = {J,K}.
- q_model  output  WIDTH  registered expected flip-flop state.
- tc  output  1  terminal count (combinational).
- fault  output  1  sticky mismatch flag.
- load_err  output  1  one-cycle pulse on an illegal load.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- States: CLEAR, RUN, FAULT.
- rst high at posedge: state=CLEAR, q_model=0, fault=0, load_err=0. rst overrides everything, including an operation in progress and FAULT.
- Per-bit excitation codes:
  - hold = 00
  - set (0->1) = 10
  - clear (1->0) = 01
  - no change = 00
- CLEAR: jk = 01 on every bit, independent of q_fb. The next posedge moves to RUN with q_model=0, so the flip-flops read 0 from that edge onward.
- RUN, next-state selection (nxt):
  - load=1 and load_val<MODULUS: nxt=load_val.
  - load=1 and load_val>=MODULUS: nxt=q_fb, and load_err pulses high for one cycle after the edge.
  - else en=1, up_dn=1: nxt = (q_fb==MODULUS-1) ? 0 : q_fb+1.
  - else en=1, up_dn=0: nxt = (q_fb==0) ? MODULUS-1 : q_fb-1.
  - else: nxt=q_fb.
- RUN outputs:
  - jk is combinational from q_fb and nxt using the per-bit codes, so the flip-flops reach nxt at the same posedge.
  - q_model <= nxt at each posedge.
- Mismatch check: at each RUN posedge, q_fb is compared with q_model. If they differ, state goes to FAULT and fault goes high. q_model is not updated on that edge.
- FAULT: jk = all 00 (flip-flops hold). en, load and up_dn are ignored. The state is left only via rst.
- tc = (state==RUN) & en & ~load & (up_dn ? q_fb==MODULUS-1 : q_fb==0).
- Arithmetic: all compares and increments are WIDTH bits. When MODULUS=2^WIDTH the wrap coincides with natural overflow.
- Simultaneous load and en: load wins and tc stays 0.
- The check on the first RUN edge compares q_fb against q_model=0.

Optional Feature:
- Macro: JK_TOGGLE_EN.
- When defined, every bit that changes is driven with 11 (toggle) instead of 10/01; hold stays 00. CLEAR still drives 01.
- When undefined, the set/clear encoding above applies.
- Counting results, tc, fault and q_model are identical in both builds; only the jk bit patterns differ.

Test Plan (WIDTH=4, MODULUS=10, with the JK flip-flop bank modelled downstream):
- Reset, then en=1, up_dn=1 for 12 cycles: CLEAR cycle drives jk=8'b01010101; q_fb runs 0,1,…,9,0,1; tc is high only while q_fb=9; fault=0.
- From q_fb=0, up_dn=0, en=1: next value is 9 and tc is high at 0. From q_fb=9->8, the changing bits give jk bit pairs {01 on bit0, 00 elsewhere}.
- load=1, load_val=7, en=1: next q_fb=7 and tc=0. Then load_val=12: q_fb unchanged, load_err pulses for exactly 1 cycle.
- In RUN at q_fb=3, force a flip-flop bit to flip externally: fault rises on the next posedge and jk=00000000 thereafter. Assert rst for 1 cycle: fault=0 and CLEAR resumes.
- en=0, load=0 for 5 cycles: jk=all 00, q_fb holds and q_model is constant.
- JK_TOGGLE_EN defined, step 7->8: jk=8'b11111111 (bits 0-3 all change), and q_fb sequence matches the default build.
